pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 23 ++
 rtl/pc_phase_counter.sv | 38 +++
 rtl/pc_unit.sv | 102 ++++++++++
 tb/tb_pc_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants, next-PC source encoding and sizing helpers for the
// program counter block.
package pc_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_PERIOD     = 10;
   localparam int DEF_STEP       = 4;
   localparam int DEF_RESET_ADDR = 0;
   localparam int DEF_ALIGN      = 2;

   // Source of the value loaded into the PC at a commit edge.
   typedef enum logic [1:0] {
      SEQ    = 2'd0,
      BRANCH = 2'd1,
      JUMP   = 2'd2
   } next_sel_e;

   // A one-state phase counter still needs a one-bit port.
   function automatic int phase_width(input int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

endpackage

// File: rtl/pc_phase_counter.sv
// Instruction-step phase counter; raises commit on the last phase of a
// step whenever the pipeline is not stalled.
module pc_phase_counter
   import pc_pkg::*;
#(
   parameter int PERIOD = DEF_PERIOD
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           stall,
   output logic [phase_width(PERIOD)-1:0] fase,
   output logic                           commit
);

   localparam int FW = phase_width(PERIOD);
   localparam logic [FW-1:0] LAST_PHASE = FW'(PERIOD - 1);

   logic [FW-1:0] fase_r;
   logic          last_s;

   assign last_s = (fase_r == LAST_PHASE);
   assign commit = ~stall & last_s;
   assign fase   = fase_r;

   // Phase register: advances on every non-stalled edge, wraps after the last phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         fase_r <= {FW{1'b0}};
      end else if (stall) begin
         fase_r <= fase_r;
      end else if (last_s) begin
         fase_r <= {FW{1'b0}};
      end else begin
         fase_r <= fase_r + FW'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter: loads a sequential, branch or jump address once per
// instruction step, rejecting misaligned targets with a sticky flag.
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter int               PERIOD     = DEF_PERIOD,
   parameter int               STEP       = DEF_STEP,
   parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR),
   parameter int               ALIGN      = DEF_ALIGN
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           stall,
   input  logic                           desvio,
   input  logic [WIDTH-1:0]               alvo_desvio,
   input  logic                           salto,
   input  logic [WIDTH-1:0]               alvo_salto,
   output logic [WIDTH-1:0]               estado_pc,
   output logic [phase_width(PERIOD)-1:0] fase,
   output logic                           pc_atualizado,
   output logic                           erro_alinhamento
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN) - 64'd1);
   localparam logic [WIDTH-1:0] STEP_INC   = WIDTH'(STEP);

   logic [WIDTH-1:0] pc_r;
   logic             pulse_r;
   logic             err_r;
   logic             commit_s;
   next_sel_e        sel_s;
   logic [WIDTH-1:0] seq_s;
   logic [WIDTH-1:0] target_s;
   logic             misaligned_s;

   pc_phase_counter #(
      .PERIOD (PERIOD)
   ) u_phase (
      .clock  (clock),
      .reset  (reset),
      .stall  (stall),
      .fase   (fase),
      .commit (commit_s)
   );

   // Sequential path wraps naturally modulo 2^WIDTH.
   assign seq_s = pc_r + STEP_INC;

   // Next-PC source select (jump beats branch) and target alignment check.
   always_comb begin
      sel_s        = SEQ;
      target_s     = seq_s;
      misaligned_s = 1'b0;
      if (salto) begin
         sel_s = JUMP;
      end else if (desvio) begin
         sel_s = BRANCH;
      end else begin
         sel_s = SEQ;
      end
      case (sel_s)
         JUMP:    target_s = alvo_salto;
         BRANCH:  target_s = alvo_desvio;
         SEQ:     target_s = seq_s;
         default: target_s = seq_s;
      endcase
      if (sel_s == SEQ) begin
         misaligned_s = 1'b0;
      end else begin
         misaligned_s = |(target_s & ALIGN_MASK);
      end
   end

   // PC, load pulse and sticky alignment error; a rejected target leaves the PC untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_r    <= RESET_ADDR;
         pulse_r <= 1'b0;
         err_r   <= 1'b0;
      end else if (commit_s) begin
         if (misaligned_s) begin
            pc_r    <= pc_r;
            pulse_r <= 1'b0;
            err_r   <= 1'b1;
         end else begin
            pc_r    <= target_s;
            pulse_r <= 1'b1;
            err_r   <= err_r;
         end
      end else begin
         pc_r    <= pc_r;
         pulse_r <= 1'b0;
         err_r   <= err_r;
      end
   end

   assign estado_pc        = pc_r;
   assign pc_atualizado    = pulse_r;
   assign erro_alinhamento = err_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: default 32-bit/10-phase unit, an 8-bit
// wrap-around instance and a single-phase instance.
module tb_pc_unit;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int pulses   = 0;

   // Default instance
   logic        r0 = 1'b1, s0 = 1'b0, d0 = 1'b0, j0 = 1'b0;
   logic [31:0] ad0 = 32'h0, aj0 = 32'h0, pc0;
   logic [3:0]  f0;
   logic        p0, e0;

   // 8-bit instance, resets to 0xFC, two phases per step
   logic        r8 = 1'b1, s8 = 1'b0, d8 = 1'b0, j8 = 1'b0;
   logic [7:0]  ad8 = 8'h0, aj8 = 8'h0, pc8;
   logic [0:0]  f8;
   logic        p8, e8;

   // Single-phase instance, 16-bit, resets to 0x10
   logic        r1 = 1'b1, s1 = 1'b0, d1 = 1'b0, j1 = 1'b0;
   logic [15:0] ad1 = 16'h0, aj1 = 16'h0, pc1;
   logic [0:0]  f1;
   logic        p1, e1;

   pc_unit u_dut0 (
      .clock(clock), .reset(r0), .stall(s0),
      .desvio(d0), .alvo_desvio(ad0), .salto(j0), .alvo_salto(aj0),
      .estado_pc(pc0), .fase(f0), .pc_atualizado(p0), .erro_alinhamento(e0)
   );

   pc_unit #(.WIDTH(8), .PERIOD(2), .STEP(4), .RESET_ADDR(8'hFC), .ALIGN(2)) u_dut8 (
      .clock(clock), .reset(r8), .stall(s8),
      .desvio(d8), .alvo_desvio(ad8), .salto(j8), .alvo_salto(aj8),
      .estado_pc(pc8), .fase(f8), .pc_atualizado(p8), .erro_alinhamento(e8)
   );

   pc_unit #(.WIDTH(16), .PERIOD(1), .STEP(4), .RESET_ADDR(16'h0010), .ALIGN(2)) u_dut1 (
      .clock(clock), .reset(r1), .stall(s1),
      .desvio(d1), .alvo_desvio(ad1), .salto(j1), .alvo_salto(aj1),
      .estado_pc(pc1), .fase(f1), .pc_atualizado(p1), .erro_alinhamento(e1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      // Reset state
      tick(1);
      check("rst_pc", pc0, 32'h0);
      check("rst_fase", {28'h0, f0}, 32'd0);
      check("rst_pulse", {31'h0, p0}, 32'd0);
      check("rst_err", {31'h0, e0}, 32'd0);

      // Free run for 30 edges; desvio held high except on commit edges must be ignored
      r0  = 1'b0;
      d0  = 1'b1;
      ad0 = 32'h40;
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         check("run_pc", pc0, 32'(4 * (k / 10)));
         check("run_fase", {28'h0, f0}, 32'(k % 10));
         check("run_pulse", {31'h0, p0}, (k % 10 == 0) ? 32'd1 : 32'd0);
         if (p0) pulses++;
         d0 = ((k % 10) != 9);
      end
      d0 = 1'b0;
      check("run_pulse_count", 32'(pulses), 32'd3);

      // Jump beats branch
      tick(9);
      check("pre_jump_fase", {28'h0, f0}, 32'd9);
      j0 = 1'b1; aj0 = 32'h100; d0 = 1'b1; ad0 = 32'h200;
      tick(1);
      j0 = 1'b0; d0 = 1'b0;
      check("jump_pc", pc0, 32'h100);
      check("jump_pulse", {31'h0, p0}, 32'd1);
      check("jump_fase", {28'h0, f0}, 32'd0);

      // Stall on the would-be commit edge for 5 cycles
      tick(9);
      s0 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check("stall_fase", {28'h0, f0}, 32'd9);
         check("stall_pc", pc0, 32'h100);
         check("stall_pulse", {31'h0, p0}, 32'd0);
      end
      s0 = 1'b0;
      tick(1);
      check("unstall_pc", pc0, 32'h104);
      check("unstall_pulse", {31'h0, p0}, 32'd1);
      check("unstall_fase", {28'h0, f0}, 32'd0);

      // Misaligned branch target is rejected, error sticks
      tick(9);
      d0 = 1'b1; ad0 = 32'h102;
      tick(1);
      d0 = 1'b0;
      check("misal_pc", pc0, 32'h104);
      check("misal_err", {31'h0, e0}, 32'd1);
      check("misal_pulse", {31'h0, p0}, 32'd0);
      check("misal_fase", {28'h0, f0}, 32'd0);
      tick(10);
      check("after_misal_pc", pc0, 32'h108);
      check("after_misal_pulse", {31'h0, p0}, 32'd1);
      check("after_misal_err", {31'h0, e0}, 32'd1);

      // Reset on a commit edge dominates a pending jump
      tick(9);
      j0 = 1'b1; aj0 = 32'h300; r0 = 1'b1;
      tick(1);
      j0 = 1'b0; r0 = 1'b0;
      check("rstc_pc", pc0, 32'h0);
      check("rstc_fase", {28'h0, f0}, 32'd0);
      check("rstc_pulse", {31'h0, p0}, 32'd0);
      check("rstc_err", {31'h0, e0}, 32'd0);
      tick(9);
      check("rstc_hold_pc", pc0, 32'h0);
      tick(1);
      check("rstc_first_pc", pc0, 32'h4);
      check("rstc_first_pulse", {31'h0, p0}, 32'd1);

      // 8-bit wrap: 0xFC + 4 -> 0x00, no error
      tick(1);
      check("w8_rst_pc", {24'h0, pc8}, 32'hFC);
      r8 = 1'b0;
      tick(1);
      check("w8_mid_pc", {24'h0, pc8}, 32'hFC);
      check("w8_mid_fase", {31'h0, f8}, 32'd1);
      tick(1);
      check("w8_wrap_pc", {24'h0, pc8}, 32'h00);
      check("w8_wrap_pulse", {31'h0, p8}, 32'd1);
      check("w8_wrap_err", {31'h0, e8}, 32'd0);

      // Single phase: every non-stalled edge commits
      tick(1);
      check("p1_rst_pc", {16'h0, pc1}, 32'h10);
      r1 = 1'b0;
      tick(1);
      check("p1_pc_a", {16'h0, pc1}, 32'h14);
      check("p1_pulse_a", {31'h0, p1}, 32'd1);
      tick(1);
      check("p1_pc_b", {16'h0, pc1}, 32'h18);
      check("p1_fase", {31'h0, f1}, 32'd0);
      s1 = 1'b1;
      tick(1);
      check("p1_stall_pc", {16'h0, pc1}, 32'h18);
      check("p1_stall_pulse", {31'h0, p1}, 32'd0);
      s1 = 1'b0;
      j1 = 1'b1; aj1 = 16'h0200;
      tick(1);
      j1 = 1'b0;
      check("p1_jump_pc", {16'h0, pc1}, 32'h200);
      check("p1_jump_pulse", {31'h0, p1}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
